// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - program-counter generator with redirect arbitration, IF handshake and pending redirect capture
// Optional build macro: PC_MISALIGN_TRAP_EN (adds trap_vector_i / misaligned_o and misaligned-target replacement)
module pc_gen_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     INST_BYTES = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            enable_design,
   input  logic [XLEN-1:0] initial_pc_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   input  logic            pc_ready_i,
   input  logic            jump_i,
   input  logic            branch_i,
   input  logic [XLEN-1:0] target_i,
   input  logic            irq_i,
   input  logic [XLEN-1:0] irq_vector_i,
   input  logic            mret_i,
   input  logic [XLEN-1:0] mepc_i,
`ifdef PC_MISALIGN_TRAP_EN
   input  logic [XLEN-1:0] trap_vector_i,
   output logic            misaligned_o,
`endif
   output logic            redirect_o,
   output logic            redirect_pending_o,
   output logic [XLEN-1:0] next_pc_o
);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] PC_INC = XLEN'(INST_BYTES);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pend_valid_q, pend_valid_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;

   logic            live_req;
   logic [XLEN-1:0] live_raw;
   logic [XLEN-1:0] live_tgt;
   logic [XLEN-1:0] seq_pc;
   logic            pc_valid;
   logic            redirect;
   logic [XLEN-1:0] next_pc;

`ifdef PC_MISALIGN_TRAP_EN
   logic            pend_mis_q, pend_mis_d;
   logic            live_mis;
   logic            mis_pulse;
`endif

   // Pick the winning live redirect source: mret beats irq beats jump/branch.
   always_comb begin
      live_req = mret_i | irq_i | jump_i | branch_i;
      live_raw = target_i;
      if (mret_i) begin
         live_raw = mepc_i;
      end else if (irq_i) begin
         live_raw = irq_vector_i;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   // Swap a misaligned redirect target for the trap vector; mret targets included.
   always_comb begin
      live_mis = 1'b0;
      if (INST_BYTES == 2) begin
         live_mis = live_raw[0];
      end else begin
         live_mis = |live_raw[1:0];
      end
      live_tgt = live_mis ? trap_vector_i : live_raw;
   end
`else
   // Targets pass through untouched when the misalignment trap is not built.
   always_comb begin
      live_tgt = live_raw;
   end
`endif

   assign seq_pc = pc_q + PC_INC;

   // Next-state, PC update and handshake outputs; disabled cycles keep every flop.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      pc_valid     = 1'b0;
      redirect     = 1'b0;
      next_pc      = seq_pc;
`ifdef PC_MISALIGN_TRAP_EN
      pend_mis_d   = pend_mis_q;
      mis_pulse    = 1'b0;
`endif

      case (state_q)
         ST_INIT: begin
            // Redirects are ignored until the first PC has been loaded.
            next_pc = initial_pc_i;
            if (enable_design) begin
               pc_d         = initial_pc_i;
               state_d      = ST_RUN;
               pend_valid_d = 1'b0;
            end
         end

         ST_RUN: begin
            pc_valid = enable_design;
            next_pc  = live_req ? live_tgt : seq_pc;
            if (enable_design) begin
               if (live_req) begin
                  // Redirects in RUN apply immediately, ready or not.
                  pc_d     = live_tgt;
                  redirect = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                  mis_pulse = live_mis;
`endif
               end else if (pc_ready_i) begin
                  pc_d = seq_pc;
               end else begin
                  state_d = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            pc_valid = enable_design;
            if (live_req) begin
               next_pc = live_tgt;
            end else if (pend_valid_q) begin
               next_pc = pend_pc_q;
            end
            if (enable_design) begin
               if (pc_ready_i) begin
                  state_d      = ST_RUN;
                  pend_valid_d = 1'b0;
                  if (live_req) begin
                     // A live redirect supersedes whatever was pending.
                     pc_d     = live_tgt;
                     redirect = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                     mis_pulse = live_mis;
`endif
                  end else if (pend_valid_q) begin
                     pc_d     = pend_pc_q;
                     redirect = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                     mis_pulse = pend_mis_q;
`endif
                  end else begin
                     pc_d = seq_pc;
                  end
               end else if (live_req) begin
                  // Stalled: park the newest redirect, overwriting any older one.
                  pend_valid_d = 1'b1;
                  pend_pc_d    = live_tgt;
`ifdef PC_MISALIGN_TRAP_EN
                  pend_mis_d   = live_mis;
`endif
               end
            end
         end

         default: begin
            state_d      = ST_INIT;
            pend_valid_d = 1'b0;
         end
      endcase
   end

   // State, PC and pending-redirect registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q      <= ST_INIT;
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
         pend_mis_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
`ifdef PC_MISALIGN_TRAP_EN
         pend_mis_q   <= pend_mis_d;
`endif
      end
   end

   assign pc_o               = pc_q;
   assign pc_valid_o         = pc_valid;
   assign redirect_o         = redirect;
   assign redirect_pending_o = pend_valid_q;
   assign next_pc_o          = next_pc;
`ifdef PC_MISALIGN_TRAP_EN
   assign misaligned_o       = mis_pulse;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - table-driven self-checking bench for pc_gen_unit
module tb_pc_gen_unit;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        enable_design;
   logic [31:0] initial_pc_i;
   logic [31:0] pc_o;
   logic        pc_valid_o;
   logic        pc_ready_i;
   logic        jump_i;
   logic        branch_i;
   logic [31:0] target_i;
   logic        irq_i;
   logic [31:0] irq_vector_i;
   logic        mret_i;
   logic [31:0] mepc_i;
   logic        redirect_o;
   logic        redirect_pending_o;
   logic [31:0] next_pc_o;
`ifdef PC_MISALIGN_TRAP_EN
   logic [31:0] trap_vector_i;
   logic        misaligned_o;
`endif

   pc_gen_unit #(.XLEN(32), .INST_BYTES(4), .RESET_PC(32'h0)) dut (
      .clk_i              (clk_i),
      .reset_i            (reset_i),
      .enable_design      (enable_design),
      .initial_pc_i       (initial_pc_i),
      .pc_o               (pc_o),
      .pc_valid_o         (pc_valid_o),
      .pc_ready_i         (pc_ready_i),
      .jump_i             (jump_i),
      .branch_i           (branch_i),
      .target_i           (target_i),
      .irq_i              (irq_i),
      .irq_vector_i       (irq_vector_i),
      .mret_i             (mret_i),
      .mepc_i             (mepc_i),
`ifdef PC_MISALIGN_TRAP_EN
      .trap_vector_i      (trap_vector_i),
      .misaligned_o       (misaligned_o),
`endif
      .redirect_o         (redirect_o),
      .redirect_pending_o (redirect_pending_o),
      .next_pc_o          (next_pc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic        rdy;
      logic        jmp;
      logic        br;
      logic [31:0] tgt;
      logic        irq;
      logic [31:0] irqv;
      logic        mret;
      logic [31:0] mepc;
      logic [31:0] init;
      logic        chk_comb;
      logic        chk_next;
      logic        e_valid;
      logic        e_redir;
      logic [31:0] e_next;
      logic [31:0] e_pc;
      logic        e_pend;
   } vec_t;

   vec_t tbl[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(logic rst_n, logic en, logic rdy, logic jmp, logic br,
                               logic [31:0] tgt, logic irq, logic [31:0] irqv,
                               logic mret, logic [31:0] mepc, logic [31:0] init,
                               logic chk_comb, logic chk_next, logic e_valid, logic e_redir,
                               logic [31:0] e_next, logic [31:0] e_pc, logic e_pend);
      vec_t v;
      v.rst_n = rst_n; v.en = en; v.rdy = rdy; v.jmp = jmp; v.br = br; v.tgt = tgt;
      v.irq = irq; v.irqv = irqv; v.mret = mret; v.mepc = mepc; v.init = init;
      v.chk_comb = chk_comb; v.chk_next = chk_next; v.e_valid = e_valid;
      v.e_redir = e_redir; v.e_next = e_next; v.e_pc = e_pc; v.e_pend = e_pend;
      return v;
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive_idle();
      jump_i = 1'b0; branch_i = 1'b0; irq_i = 1'b0; mret_i = 1'b0;
      target_i = '0; irq_vector_i = '0; mepc_i = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset_i = 1'b0; enable_design = 1'b0; pc_ready_i = 1'b0;
      initial_pc_i = 32'h0000_1000;
      drive_idle();
`ifdef PC_MISALIGN_TRAP_EN
      trap_vector_i = 32'h0000_0080;
`endif

      // rst en rdy jmp br tgt irq irqv mret mepc init | cc cn valid redir next pc_after pend_after
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,0,0,32'h1000,32'h1000,0));
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h1004,32'h1004,0));
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h1008,32'h1008,0));
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h100C,32'h100C,0));
      tbl.push_back(mk(1,1,1,1,0,32'h2000,0,32'h0,0,32'h0,32'h1000, 1,1,1,1,32'h2000,32'h2000,0));
      tbl.push_back(mk(1,1,1,1,0,32'h3000,1,32'h100,0,32'h0,32'h1000, 1,1,1,1,32'h0100,32'h0100,0));
      tbl.push_back(mk(1,1,0,1,0,32'h2000,0,32'h0,0,32'h0,32'h1000, 1,1,1,1,32'h2000,32'h2000,0));
      tbl.push_back(mk(1,1,0,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h2004,32'h2000,0));
      tbl.push_back(mk(1,1,0,0,1,32'h4000,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h4000,32'h2000,1));
      tbl.push_back(mk(1,1,0,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h4000,32'h2000,1));
      tbl.push_back(mk(1,1,0,0,0,32'h0,0,32'h0,1,32'h5000,32'h1000, 1,1,1,0,32'h5000,32'h2000,1));
      for (int i = 0; i < 5; i++) begin
         tbl.push_back(mk(1,0,1,0,(i % 2 == 0),32'h6000,0,32'h0,0,32'h0,32'h1000,
                          1,0,0,0,32'h0,32'h2000,1));
      end
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,1,32'h5000,32'h5000,0));
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h5004,32'h5004,0));
      tbl.push_back(mk(1,1,1,1,0,32'hFFFF_FFFC,0,32'h0,0,32'h0,32'h1000, 1,1,1,1,32'hFFFF_FFFC,32'hFFFF_FFFC,0));
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h0,32'h0,0));
      tbl.push_back(mk(1,1,0,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h4,32'h0,0));
      tbl.push_back(mk(1,1,0,0,1,32'h7000,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h7000,32'h0,1));
      tbl.push_back(mk(1,1,1,1,0,32'h8000,0,32'h0,0,32'h0,32'h1000, 1,1,1,1,32'h8000,32'h8000,0));
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h8004,32'h8004,0));
      tbl.push_back(mk(1,1,0,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h8008,32'h8004,0));
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h8008,32'h8008,0));
      tbl.push_back(mk(1,1,0,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 1,1,1,0,32'h800C,32'h8008,0));
      tbl.push_back(mk(1,1,0,0,0,32'h0,1,32'hA00,0,32'h0,32'h1000, 1,1,1,0,32'h0A00,32'h8008,1));
      tbl.push_back(mk(0,1,0,0,0,32'h0,0,32'h0,0,32'h0,32'h1000, 0,0,0,0,32'h0,32'h0,0));
      tbl.push_back(mk(1,1,1,1,0,32'hB000,0,32'h0,0,32'h0,32'h9000, 1,1,0,0,32'h9000,32'h9000,0));
      tbl.push_back(mk(1,1,1,0,0,32'h0,0,32'h0,0,32'h0,32'h9000, 1,1,1,0,32'h9004,32'h9004,0));
      tbl.push_back(mk(1,1,1,1,0,32'hE000,1,32'hD00,1,32'hC000,32'h9000, 1,1,1,1,32'hC000,32'hC000,0));

      // Reset state, then INIT must hold while disabled.
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_pc", -1, pc_o, 32'h0);
      check("reset_valid", -1, {31'b0, pc_valid_o}, 32'h0);
      check("reset_redirect", -1, {31'b0, redirect_o}, 32'h0);
      check("reset_pending", -1, {31'b0, redirect_pending_o}, 32'h0);
      @(negedge clk_i);
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("init_hold_pc", -1, pc_o, 32'h0);

      foreach (tbl[i]) begin
         @(negedge clk_i);
         reset_i       = tbl[i].rst_n;
         enable_design = tbl[i].en;
         pc_ready_i    = tbl[i].rdy;
         jump_i        = tbl[i].jmp;
         branch_i      = tbl[i].br;
         target_i      = tbl[i].tgt;
         irq_i         = tbl[i].irq;
         irq_vector_i  = tbl[i].irqv;
         mret_i        = tbl[i].mret;
         mepc_i        = tbl[i].mepc;
         initial_pc_i  = tbl[i].init;
         #1;
         if (tbl[i].chk_comb) begin
            check("pc_valid", i, {31'b0, pc_valid_o}, {31'b0, tbl[i].e_valid});
            check("redirect", i, {31'b0, redirect_o}, {31'b0, tbl[i].e_redir});
         end
         if (tbl[i].chk_next) begin
            check("next_pc", i, next_pc_o, tbl[i].e_next);
         end
         @(posedge clk_i);
         #1;
         check("pc", i, pc_o, tbl[i].e_pc);
         check("pending", i, {31'b0, redirect_pending_o}, {31'b0, tbl[i].e_pend});
      end

      // Misaligned jump target (running at 0xC000, ready high).
      @(negedge clk_i);
      drive_idle();
      reset_i = 1'b1; enable_design = 1'b1; pc_ready_i = 1'b1;
      jump_i = 1'b1; target_i = 32'h0000_3002;
      #1;
      check("mis_redirect", 100, {31'b0, redirect_o}, 32'h1);
`ifdef PC_MISALIGN_TRAP_EN
      check("mis_flag", 100, {31'b0, misaligned_o}, 32'h1);
      check("mis_next", 100, next_pc_o, 32'h0000_0080);
      @(posedge clk_i);
      #1;
      check("mis_pc", 100, pc_o, 32'h0000_0080);
      @(negedge clk_i);
      drive_idle();
      #1;
      check("mis_flag_clear", 101, {31'b0, misaligned_o}, 32'h0);
      check("mis_seq_next", 101, next_pc_o, 32'h0000_0084);
`else
      check("mis_next", 100, next_pc_o, 32'h0000_3002);
      @(posedge clk_i);
      #1;
      check("mis_pc", 100, pc_o, 32'h0000_3002);
      @(negedge clk_i);
      drive_idle();
      #1;
      check("mis_seq_next", 101, next_pc_o, 32'h0000_3006);
`endif
      @(posedge clk_i);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
